// File: rtl/iterative_left_shift_of_n.sv
// iterative_left_shift_of_n: valid/ready left shifter that moves the operand one bit per clock.
// Define ITERATIVE_LEFT_SHIFT_ROTATE_EN to rotate left instead of shifting in zeros.
module iterative_left_shift_of_n #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shamt,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state;
  logic [N-1:0]  sr;
  logic [SW-1:0] cnt;
  logic          fill;
`ifdef ITERATIVE_LEFT_SHIFT_ROTATE_EN
  assign fill = sr[N-1];
`else
  assign fill = 1'b0;
`endif
  assign up_ready   = state == IDLE;
  assign down_valid = state == DONE;
  assign down_data  = sr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (up_valid) begin
          sr    <= up_data;
          cnt   <= up_shamt;
          state <= up_shamt == '0 ? DONE : SHIFT;
        end
        SHIFT: begin
          sr  <= {sr[N-2:0], fill};
          cnt <= cnt - SW'(1);
          if (cnt == SW'(1)) state <= DONE;
        end
        DONE: if (down_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_left_shift_of_n.sv
// tb_iterative_left_shift_of_n: directed checks of handshake, latency and shift results for N=8.
module tb_iterative_left_shift_of_n;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_valid = 1'b0;
  logic       up_ready;
  logic [7:0] up_data = '0;
  logic [2:0] up_shamt = '0;
  logic       down_valid;
  logic       down_ready = 1'b0;
  logic [7:0] down_data;
  int passed = 0;
  int total  = 0;
  int acc    = 0;
  int res    = 0;

  iterative_left_shift_of_n #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_shamt(up_shamt),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst) begin
    if (up_valid && up_ready) acc++;
    if (down_valid && down_ready) res++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mdl(input logic [7:0] d, input int s);
`ifdef ITERATIVE_LEFT_SHIFT_ROTATE_EN
    logic [15:0] w;
    w = {d, d} << s;
    return w[15:8];
`else
    return d << s;
`endif
  endfunction

  task automatic op(input logic [7:0] d, input int s, input logic [7:0] exp, input int hold, input string tag);
    int n;
    up_valid = 1'b1;
    up_data  = d;
    up_shamt = 3'(s);
    down_ready = 1'b0;
    chk({tag, "_ready_before"}, up_ready, 1);
    tick();
    up_valid = 1'b0;
    n = 1;
    while (!down_valid && n < 40) begin
      chk({tag, "_busy"}, up_ready, 0);
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, s + 1);
    chk({tag, "_data"}, down_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, down_valid, 1);
      chk({tag, "_hold_data"}, down_data, exp);
      chk({tag, "_hold_ready"}, up_ready, 0);
    end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    chk({tag, "_release_ready"}, up_ready, 1);
    chk({tag, "_release_valid"}, down_valid, 0);
  endtask

  initial begin
    logic [7:0] d;
    int n;
    up_valid = 1'b1;
    up_data  = 8'h55;
    up_shamt = 3'd2;
    tick();
    chk("rst1_ready", up_ready, 1);
    chk("rst1_valid", down_valid, 0);
    tick();
    chk("rst2_ready", up_ready, 1);
    chk("rst2_valid", down_valid, 0);
    chk("rst2_data", down_data, 8'h00);
    rst = 1'b0;
    up_valid = 1'b0;
    tick();
    chk("idle_ready", up_ready, 1);
    chk("idle_valid", down_valid, 0);
`ifdef ITERATIVE_LEFT_SHIFT_ROTATE_EN
    op(8'hFF, 3, 8'hFF, 0, "basic");
`else
    op(8'hFF, 3, 8'hF8, 0, "basic");
`endif
    op(8'hA5, 0, 8'hA5, 0, "zero");
    up_valid = 1'b1;
    up_data  = 8'h81;
    up_shamt = 3'd7;
    tick();
    up_valid = 1'b0;
    n = 1;
    while (!down_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_latency", n, 8);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        up_valid = 1'b1;
        up_data  = 8'h55;
        up_shamt = 3'd1;
      end
      if (i == 2) up_valid = 1'b0;
`ifdef ITERATIVE_LEFT_SHIFT_ROTATE_EN
      chk("bp_data", down_data, 8'hC0);
`else
      chk("bp_data", down_data, 8'h80);
`endif
      chk("bp_valid", down_valid, 1);
      chk("bp_ready", up_ready, 0);
      tick();
    end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    chk("bp_release_ready", up_ready, 1);
    op(8'h55, 1, 8'hAA, 0, "bp_next");
    up_valid = 1'b1;
    up_data  = 8'h0F;
    up_shamt = 3'd5;
    tick();
    up_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", up_ready, 1);
    chk("mid_rst_valid", down_valid, 0);
    chk("mid_rst_data", down_data, 8'h00);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n += int'(down_valid);
    end
    chk("mid_rst_no_result", n, 0);
    for (int s = 0; s < 8; s++) begin
      d = 8'($urandom);
      op(d, s, mdl(d, s), int'($urandom_range(0, 3)), $sformatf("sweep%0d", s));
    end
    tick();
    chk("result_count", res, acc - 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/iterative_left_shift_of_n.md
# iterative_left_shift_of_N

Sequential, parameterized left shifter that moves an unsigned N-bit operand left by a run-time amount, one bit position per clock. Operand and result travel over valid/ready handshakes. It is the multi-cycle, variable-amount counterpart to the combinational fixed right-shift blocks in the arithmetic exercises. It suits area-constrained paths where a full barrel shifter is too expensive.

## Interface
- `N`, default 8: operand and result width, at least 2.
- `SW`, default `$clog2(N)`: shift-amount width. The legal range is 0..N-1.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `up_valid` input, 1 bit: an operand is offered.
- `up_ready` output, 1 bit: the block can accept an operand.
- `up_data` input, N bits: the unsigned operand.
- `up_shamt` input, SW bits: the shift amount.
- `down_valid` output, 1 bit: a result is available.
- `down_ready` input, 1 bit: the consumer takes the result.
- `down_data` output, N bits: the shifted result. It is meaningful only while `down_valid` is high.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Internal state is a data register `sr` (N bits) and a down-counter `cnt` (SW bits).
- Output decode:
  - `up_ready` = (state == IDLE).
  - `down_valid` = (state == DONE).
  - `down_data` = `sr`.
- IDLE:
  - On `up_valid && up_ready`, load `sr <= up_data` and `cnt <= up_shamt`.
  - If `up_shamt == 0`, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each cycle, `sr <= {sr[N-2:0], fill}` and `cnt <= cnt - 1`.
  - Without rotate, `fill` is 1'b0.
  - When `cnt == 1`, the state goes to DONE on the same edge as the final shift.
- DONE:
  - Hold `sr`.
  - On `down_ready`, go to IDLE.
  - `down_valid` must not drop and `down_data` must not change until `down_ready` is seen.
- `up_valid` outside IDLE is ignored. The upstream holds its data because `up_ready` is low.
- Accept and release never overlap. `up_ready` is not asserted in DONE, even when `down_ready` is high.
- Arithmetic:
  - Bits shifted past bit N-1 are discarded.
  - The result equals `(up_data << up_shamt)` truncated to N bits.
  - There is no sign handling.
- Out-of-range amounts: if N is not a power of two, `up_shamt` values of N or more are legal encodings. They shift `up_shamt` times, so the result is all zeros (rotate: mod-N behaviour follows naturally).
- Reset:
  - Values after reset: state IDLE, `sr = 0`, `cnt = 0`.
  - Outputs after reset: `up_ready = 1`, `down_valid = 0`, `down_data = 0`.
- Reset mid-operation:
  - An asserted `rst` overrides everything on that edge, including a transfer in SHIFT or DONE.
  - The pending result is dropped and no `down_valid` follows.

## Timing
- An operand is accepted at edge k. `down_valid` is first high in cycle k+s+1, where s = `up_shamt`.
- Latency is therefore s+1 cycles, uniformly for s = 0 as well.
- The result is released at edge m, when `down_valid && down_ready` is true. `up_ready` is high in cycle m+1.
- Minimum initiation interval is s+2 cycles, with `down_ready` tied high.
- There is no combinational path from inputs to outputs. All outputs decode from registers.

## Configuration
- Macro: `ITERATIVE_LEFT_SHIFT_ROTATE_EN`.
- When defined, `fill = sr[N-1]`. The block performs a rotate left, so the result equals `up_data` rotated left by s.
- When undefined, `fill = 1'b0`, giving a logical left shift.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
All scenarios use N=8.
- **Reset:** hold `rst` for 2 cycles with `up_valid=1`.
  - Then `up_ready=1`, `down_valid=0`, `down_data=8'h00`, and nothing is accepted during reset.
- **Basic shift:** `up_data=8'hFF`, `up_shamt=3`, `down_ready=1`.
  - `down_valid` is first high exactly 4 cycles after accept.
  - `down_data=8'hF8` (rotate build: 8'hFF).
  - `up_ready` returns the cycle after release.
- **Zero shift:** `up_data=8'hA5`, `up_shamt=0`.
  - `down_valid` is high in the very next cycle with `down_data=8'hA5`.
  - The FSM never enters SHIFT.
- **Backpressure:** `up_data=8'h81`, `up_shamt=7`, with `down_ready=0` for 5 cycles after `down_valid` rises.
  - The result is `8'h80` (rotate build: `8'hC0`), held stable throughout.
  - `up_ready` stays 0, and an `up_valid` pulse with `8'h55` during this window is ignored.
  - After `down_ready=1`, the next accept loads the new operand.
- **Reset mid-shift:** `up_data=8'h0F`, `up_shamt=5`, with `rst` pulsed in the second SHIFT cycle.
  - The next cycle shows `up_ready=1`, `down_valid=0`, `down_data=8'h00`.
  - No result is ever emitted for `8'h0F`.
- **Sweep:** for every `up_shamt` from 0 to 7 with random data and random `down_ready`, compare each result against `(a << s) & 8'hFF`, or the rotate model in the rotate build.
  - Latency must be s+1 and the result count must match the operand count.
